// File: rtl/div_unit.sv
// div_unit: iterative RV32M divider (DIV, DIVU, REM, REMU).
// One restoring-division step per cycle with a start/busy/done handshake.
// Divide-by-zero and signed overflow finish straight from IDLE.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             is_rem_q, is_rem_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;

    // Operand preprocessing for the IDLE capture
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             div_zero, sgn_ovf;
    // One restoring step: shifted remainder window minus divisor magnitude
    logic [WIDTH:0]   trial;

    // Sign/magnitude extraction, special-case detection and trial subtract
    always_comb begin
        a_neg    = ~op[0] & dividend[WIDTH-1];
        b_neg    = ~op[0] & divisor[WIDTH-1];
        a_mag    = a_neg ? (-dividend) : dividend;
        b_mag    = b_neg ? (-divisor) : divisor;
        div_zero = (divisor == '0);
        sgn_ovf  = ~op[0] && (dividend == MOST_NEG) && (divisor == '1);
        trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    end

    // Next-state, datapath update and result selection
    always_comb begin
        state_d  = state_q;
        is_rem_d = is_rem_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_rem_d = op[1];
                    q_neg_d  = a_neg ^ b_neg;
                    r_neg_d  = a_neg;
                    rem_d    = '0;
                    quo_d    = a_mag;
                    dvs_d    = b_mag;
                    if (div_zero) begin
                        result_d = op[1] ? dividend : '1;
                        state_d  = S_DONE;
                    end else if (sgn_ovf) begin
                        result_d = op[1] ? '0 : MOST_NEG;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d   = CW'(WIDTH);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (cnt_q != '0) begin
                    if (!trial[WIDTH]) begin
                        rem_d = trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    if (is_rem_q) begin
                        result_d = r_neg_q ? (-rem_q) : rem_q;
                    end else begin
                        result_d = q_neg_q ? (-quo_q) : quo_q;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            is_rem_q <= is_rem_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        busy   = (state_q == S_CALC);
        done   = (state_q == S_DONE);
        result = result_q;
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against an
// arithmetic reference model.
module tb_div_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // RISC-V M-extension semantics in plain 64-bit arithmetic
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (o[0]) begin
            ua = {32'd0, a};
            ub = {32'd0, b};
            return o[1] ? 32'(ua % ub) : 32'(ua / ub);
        end
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    // Issue one operation; must be called #1 after a rising edge while IDLE.
    // poke=1 drives a fresh start during CALC and during DONE.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit poke);
        logic [31:0] exp;
        bit          special;
        bit          seen;
        exp     = ref_div(o, a, b);
        special = (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        start    = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start    = 1'b0;
        op       = 2'($urandom);
        dividend = $urandom;
        divisor  = $urandom;
        seen     = 1'b0;
        for (int k = 0; k < int'(W) + 8 && !seen; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (done) begin
                seen = 1'b1;
                check({tag, " latency"}, 32'(k), special ? 32'd0 : W + 1);
                check({tag, " busy@done"}, 32'(busy), 32'd0);
                check({tag, " result"}, result, exp);
                if (poke) begin
                    start    = 1'b1;
                    op       = 2'($urandom);
                    dividend = $urandom;
                    divisor  = 32'd0;
                end
            end else begin
                check({tag, " busy"}, 32'(busy), special ? 32'd0 : 32'd1);
                if (poke && k == 5) begin
                    start    = 1'b1;
                    op       = 2'($urandom);
                    dividend = $urandom;
                    divisor  = $urandom;
                end else begin
                    start = 1'b0;
                end
            end
        end
        if (!seen) check({tag, " timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
        check({tag, " hold"}, result, exp);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 1'b0);
        run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 1'b0);
        run_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("rem 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op("div /0", 2'b00, 32'h1234_5678, 32'd0, 1'b0);
        run_op("divu /0", 2'b01, 32'h1234_5678, 32'd0, 1'b0);
        run_op("rem /0", 2'b10, 32'h1234_5678, 32'd0, 1'b0);
        run_op("remu /0", 2'b11, 32'h1234_5678, 32'd0, 1'b0);
        run_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("divu minneg/-1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("poke div", 2'b00, 32'hDEAD_BEEF, 32'd12345, 1'b1);
        run_op("after poke", 2'b11, 32'hCAFE_F00D, 32'd977, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 20));
                3:       rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if (i == 3) ra = 32'h8000_0000;
            run_op("random", ro, ra, rb, 1'(i % 5 == 0));
        end

        // Reset during CALC aborts with no done pulse
        start    = 1'b1;
        op       = 2'b01;
        dividend = 32'd1000;
        divisor  = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        check("pre-abort busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort result", result, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort no done", 32'(done), 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("post-reset done", 32'(done), 32'd0);
        check("post-reset result", result, 32'd0);
        run_op("divu max/1", 2'b01, 32'hFFFF_FFFF, 32'd1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
